// File: rtl/avlst_video_pkg.sv
// avlst_video_pkg
// Shared types and helpers for the Avalon-ST video pattern source.
//   rgb_t       : packed 8-bit R, G, B pixel
//   pattern_e   : test pattern selector encoding (matches pattern_sel values)
//   state_e     : source state machine states
//   pack_pixel  : places an RGB pixel into the 32-bit stream word {8'h00, R, G, B}
//   bit_at      : single-bit extract that stays legal for counters narrower than the bit
package avlst_video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FILL  = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_e;

    function automatic logic [31:0] pack_pixel(input rgb_t p);
        return {8'h00, p};
    endfunction

    function automatic logic bit_at(input logic [31:0] v, input int unsigned i);
        return v[i];
    endfunction

endpackage

// File: rtl/avlst_if.sv
// avlst_if
// Avalon-ST point-to-point stream bundle.
//   valid, data, startofpacket, endofpacket : source -> sink
//   ready                                   : sink -> source
interface avlst_if #(
    parameter int DATA_BYTES = 4
);
    logic                      valid;
    logic                      ready;
    logic [8*DATA_BYTES-1:0]   data;
    logic                      startofpacket;
    logic                      endofpacket;

    modport master (
        output valid, data, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  valid, data, startofpacket, endofpacket,
        output ready
    );
endinterface

// File: rtl/avlst_pattern_pixel.sv
// avlst_pattern_pixel
// Combinational pixel generator for the test patterns.
//   x_i, y_i    : pixel coordinates
//   bar_i       : colour-bar index (0..7) tracked by the caller
//   pattern_i   : latched pattern for the current frame
//   fill_i      : frame counter value captured at frame start
//   rgb_o       : resulting pixel colour
module avlst_pattern_pixel
    import avlst_video_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [2:0]    bar_i,
    input  pattern_e      pattern_i,
    input  logic [7:0]    fill_i,
    output rgb_t          rgb_o
);

    always_comb begin
        rgb_o = '0;
        unique case (pattern_i)
            PAT_BARS: begin
                rgb_o.r = {8{bar_i[2]}};
                rgb_o.g = {8{bar_i[1]}};
                rgb_o.b = {8{bar_i[0]}};
            end
            PAT_GRAD: begin
                rgb_o.r = 8'(x_i);
                rgb_o.g = 8'(x_i);
                rgb_o.b = 8'(x_i);
            end
            PAT_CHECK: begin
                // 16x16 squares; bits above the counter width read as zero
                if (bit_at(32'(x_i), 4) ^ bit_at(32'(y_i), 4)) begin
                    rgb_o = '1;
                end
            end
            PAT_FILL: begin
                rgb_o.r = fill_i;
                rgb_o.g = ~fill_i;
                rgb_o.b = 8'(y_i);
            end
            default: rgb_o = '0;
        endcase
    end

endmodule

// File: rtl/avlst_pattern_src.sv
// avlst_pattern_src
// Avalon-ST source producing one raster test frame per packet, with full
// ready backpressure and back-to-back frames while enable stays high.
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : keep starting new frames while high
//   pattern_sel  : pattern choice, latched at each frame start
//   frame_done   : one-cycle pulse when the eop beat is accepted
//   frame_cnt    : completed frames, modulo 256
//   stream       : Avalon-ST master (valid/ready/data/sop/eop)
module avlst_pattern_src
    import avlst_video_pkg::*;
#(
    parameter int H_PIXELS   = 800,
    parameter int V_PIXELS   = 480,
    parameter int DATA_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    avlst_if.master    stream
);

    localparam int XW    = $clog2(H_PIXELS);
    localparam int YW    = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam int BAR_W = H_PIXELS / 8;
    localparam int SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int DW    = 8 * DATA_BYTES;

    localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);
    localparam logic [SW-1:0] S_LAST = SW'(BAR_W - 1);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    bar_q, bar_d;
    logic [SW-1:0] sub_q, sub_d;
    pattern_e      pat_q, pat_d;
    logic [7:0]    fill_q, fill_d;
    logic          valid_q, valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic [DW-1:0] data_q, data_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic          start_frame;
    logic [7:0]    start_fill;
    rgb_t          pix_d;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        bar_d        = bar_q;
        sub_d        = sub_q;
        pat_d        = pat_q;
        fill_d       = fill_q;
        valid_d      = valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        start_frame  = 1'b0;
        start_fill   = frame_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    start_frame = 1'b1;
                    state_d     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (valid_q && stream.ready) begin
                    if (eop_q) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        if (enable) begin
                            // next frame's fill pattern shows the updated count
                            start_frame = 1'b1;
                            start_fill  = frame_cnt_d;
                        end else begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                        end
                    end else begin
                        sop_d = 1'b0;
                        if (x_q == X_LAST) begin
                            x_d   = '0;
                            y_d   = y_q + YW'(1);
                            bar_d = '0;
                            sub_d = '0;
                        end else begin
                            x_d = x_q + XW'(1);
                            // bar index advances every BAR_W pixels, no divider
                            if (sub_q == S_LAST) begin
                                sub_d = '0;
                                bar_d = bar_q + 3'd1;
                            end else begin
                                sub_d = sub_q + SW'(1);
                            end
                        end
                        eop_d = (x_d == X_LAST) && (y_d == Y_LAST);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_frame) begin
            x_d     = '0;
            y_d     = '0;
            bar_d   = '0;
            sub_d   = '0;
            pat_d   = pattern_e'(pattern_sel);
            fill_d  = start_fill;
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
        end
    end

    // Pixel for the beat about to be presented, so data is registered with valid
    avlst_pattern_pixel #(
        .XW (XW),
        .YW (YW)
    ) u_pixel (
        .x_i       (x_d),
        .y_i       (y_d),
        .bar_i     (bar_d),
        .pattern_i (pat_d),
        .fill_i    (fill_d),
        .rgb_o     (pix_d)
    );

    assign data_d = valid_d ? DW'(pack_pixel(pix_d)) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            bar_q        <= '0;
            sub_q        <= '0;
            pat_q        <= PAT_BARS;
            fill_q       <= '0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bar_q        <= bar_d;
            sub_q        <= sub_d;
            pat_q        <= pat_d;
            fill_q       <= fill_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign stream.valid         = valid_q;
    assign stream.data          = data_q;
    assign stream.startofpacket = sop_q;
    assign stream.endofpacket   = eop_q;
    assign frame_done           = frame_done_q;
    assign frame_cnt            = frame_cnt_q;

endmodule

// File: tb/tb_avlst_pattern_src.sv
module tb_avlst_pattern_src;

    localparam int H = 32;
    localparam int V = 4;
    localparam int N = H * V;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       frame_done;
    logic [7:0] frame_cnt;

    avlst_if #(.DATA_BYTES(4)) st();

    avlst_pattern_src #(
        .H_PIXELS   (H),
        .V_PIXELS   (V),
        .DATA_BYTES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .stream      (st.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pixel straight from the pattern definitions
    function automatic logic [31:0] ref_pix(input int pat, input int x, input int y, input int fc);
        int bar;
        logic [7:0] r, g, b;
        case (pat)
            0: begin
                bar = x / (H / 8);
                r = ((bar / 4) % 2 == 1) ? 8'hFF : 8'h00;
                g = ((bar / 2) % 2 == 1) ? 8'hFF : 8'h00;
                b = (bar % 2 == 1) ? 8'hFF : 8'h00;
            end
            1: begin
                r = 8'(x % 256); g = r; b = r;
            end
            2: begin
                r = (((x / 16) % 2) != ((y / 16) % 2)) ? 8'hFF : 8'h00;
                g = r; b = r;
            end
            default: begin
                r = 8'(fc % 256); g = 8'(255 - (fc % 256)); b = 8'(y % 256);
            end
        endcase
        return {8'h00, r, g, b};
    endfunction

    // Behavioural model: frame in progress, beat index, latched pattern/fill
    bit m_busy = 0;
    int m_k = 0, m_pat = 0, m_fill = 0, m_fcnt = 0;
    bit m_fd = 0;

    // Accepted-beat log
    int          cyc = 0;
    int          acc_total = 0;
    logic [31:0] beat_data[$];
    bit          beat_sop[$];
    bit          beat_eop[$];
    int          beat_cyc[$];

    bit          wrap_phase = 0;
    bit          got255 = 0, got0 = 0;
    logic [31:0] first_at255 = '0, first_at0 = '0;

    bit          rnd_ready = 0;
    bit          pv = 0, pr = 0, psop = 0, peop = 0;
    logic [31:0] pdata = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("reset_outputs", {st.valid, st.startofpacket, st.endofpacket, frame_done, frame_cnt, st.data}, '0);
            m_busy = 0; m_k = 0; m_fcnt = 0; m_fd = 0;
            pv = 0;
        end else begin
            chk("valid", st.valid, m_busy);
            if (m_busy) begin
                chk("data", st.data, ref_pix(m_pat, m_k % H, m_k / H, m_fill));
                chk("sop", st.startofpacket, m_k == 0);
                chk("eop", st.endofpacket, m_k == N - 1);
            end
            chk("frame_done", frame_done, m_fd);
            chk("frame_cnt", frame_cnt, m_fcnt);
            if (pv && !pr)
                chk("hold_stable", {st.valid, st.data, st.startofpacket, st.endofpacket}, {1'b1, pdata, psop, peop});

            if (st.valid && st.ready) begin
                beat_data.push_back(st.data);
                beat_sop.push_back(st.startofpacket);
                beat_eop.push_back(st.endofpacket);
                beat_cyc.push_back(cyc);
                acc_total++;
                if (wrap_phase && st.startofpacket) begin
                    if (frame_cnt == 8'd255 && !got255) begin got255 = 1; first_at255 = st.data; end
                    else if (frame_cnt == 8'd0 && got255 && !got0) begin got0 = 1; first_at0 = st.data; end
                end
            end

            // advance model to what the next edge produces
            m_fd = 0;
            if (!m_busy) begin
                if (enable) begin m_busy = 1; m_k = 0; m_pat = int'(pattern_sel); m_fill = m_fcnt; end
            end else if (st.ready) begin
                if (m_k == N - 1) begin
                    m_fd = 1;
                    m_fcnt = (m_fcnt + 1) % 256;
                    if (enable) begin m_k = 0; m_pat = int'(pattern_sel); m_fill = m_fcnt; end
                    else m_busy = 0;
                end else begin
                    m_k++;
                end
            end
            pv = st.valid; pr = st.ready; pdata = st.data;
            psop = st.startofpacket; peop = st.endofpacket;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) st.ready = ($urandom_range(0, 99) < 30);
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int n = 0;
        while (acc_total < target && n < budget) begin step(); n++; end
        chk(name, acc_total >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        enable = 1'b0;
        while (st.valid && n < budget) begin step(); n++; end
        chk("idle_reached", st.valid, 0);
    endtask

    int base, base2, fc0, n;

    initial begin
        st.ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Back-to-back frames of colour bars, ready always high
        base = acc_total;
        pattern_sel = 2'd0; st.ready = 1'b1; enable = 1'b1;
        chk("idle_before_enable", st.valid, 0);
        step();
        chk("first_valid_latency", st.valid, 1);
        wait_acc(base + 2 * N, 3 * N, "bars_frames_timeout");
        chk("sop_beat0", beat_sop[base], 1);
        chk("sop_beat1", beat_sop[base + 1], 0);
        chk("eop_last", beat_eop[base + N - 1], 1);
        chk("eop_early", beat_eop[base + N - 2], 0);
        chk("frame_span", beat_cyc[base + N - 1] - beat_cyc[base], N - 1);
        chk("sop_no_gap", {beat_sop[base + N], 32'(beat_cyc[base + N] - beat_cyc[base + N - 1])}, {1'b1, 32'd1});
        chk("bars_b3", beat_data[base + 3], 32'h00000000);
        chk("bars_b4", beat_data[base + 4], 32'h000000FF);
        chk("bars_b8", beat_data[base + 8], 32'h0000FF00);
        chk("bars_b31", beat_data[base + 31], 32'h00FFFFFF);
        chk("bars_line1_b5", beat_data[base + H + 5], 32'h000000FF);
        chk("frames_after_two", frame_cnt, 8'd2);
        wait_idle(4 * N);

        // Checker pattern under random 30% ready
        base = acc_total;
        pattern_sel = 2'd2; enable = 1'b1; rnd_ready = 1;
        wait_acc(base + 2 * N, 20 * N, "checker_frames_timeout");
        wait_idle(20 * N);
        rnd_ready = 0;
        n = 0;
        for (int i = 0; i < 2 * N; i++) n += beat_eop[base + i];
        chk("eops_in_two_frames", n, 2);
        chk("checker_eop_pos", {beat_eop[base + N - 1], beat_eop[base + 2 * N - 1]}, 2'b11);
        chk("checker_0_0", beat_data[base], 32'h00000000);
        chk("checker_15_0", beat_data[base + 15], 32'h00000000);
        chk("checker_16_0", beat_data[base + 16], 32'h00FFFFFF);

        // enable and pattern_sel changed mid-frame
        st.ready = 1'b1;
        fc0 = int'(frame_cnt);
        base = acc_total;
        pattern_sel = 2'd1; enable = 1'b1;
        wait_acc(base + 20, 100, "grad_b20_timeout");
        enable = 1'b0;
        wait_acc(base + 30, 100, "grad_b30_timeout");
        pattern_sel = 2'd3;
        wait_acc(base + N, 4 * N, "grad_frame_timeout");
        chk("valid_drop_after_eop", st.valid, 0);
        chk("grad_b17", beat_data[base + 17], 32'h00111111);
        chk("grad_b100", beat_data[base + 100], 32'h00040404);
        chk("grad_last", beat_data[base + N - 1], 32'h001F1F1F);
        chk("grad_frame_cnt", frame_cnt, 8'((fc0 + 1) % 256));
        repeat (4) step();
        chk("no_extra_beats", acc_total, base + N);

        // frame_cnt wrap with fill pattern
        pattern_sel = 2'd3; enable = 1'b1; wrap_phase = 1;
        n = 0;
        while (!got0 && n < 260 * N) begin step(); n++; end
        chk("wrap_reached", {got255, got0}, 2'b11);
        chk("fill_frame255", first_at255, 32'h00FF0000);
        chk("fill_frame0", first_at0, 32'h0000FF00);
        wrap_phase = 0;
        wait_idle(4 * N);

        // asynchronous reset mid-frame under backpressure
        base = acc_total;
        pattern_sel = 2'd3; enable = 1'b1; st.ready = 1'b1;
        wait_acc(base + 10, 100, "reset_b10_timeout");
        st.ready = 1'b0;
        step();
        chk("stalled_valid", st.valid, 1);
        #2 reset = 1'b1;
        #1 chk("async_reset", {st.valid, st.startofpacket, st.endofpacket, st.data, frame_cnt}, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        st.ready = 1'b1;
        base2 = acc_total;
        wait_acc(base2 + 1, 20, "post_reset_timeout");
        chk("post_reset_sop", beat_sop[base2], 1);
        chk("post_reset_data", beat_data[base2], 32'h0000FF00);
        chk("post_reset_cnt", frame_cnt, 8'd0);
        wait_idle(4 * N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avlst_pattern_src.md
Name: avlst_pattern_src

Overview:
- Avalon-ST source (master end) that generates raster video test frames for bring-up of downstream stream consumers (pixel FIFO, VGA output stage).
- One packet per frame: startofpacket on pixel (0,0), endofpacket on pixel (H_PIXELS-1, V_PIXELS-1).
- Fully honours ready backpressure, so it can replace the frame-buffer reader as stream source.

Parameters:
- H_PIXELS, 800, active pixels per line; multiple of 8, at least 8.
- V_PIXELS, 480, active lines per frame; at least 1.
- DATA_BYTES, 4, stream data width in bytes; fixed at 4 (pixel RGB in data[23:0]).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  start new frames while high.
- pattern_sel  input  2  pattern choice; sampled at frame start.
- frame_done  output  1  one-cycle pulse on the cycle the eop beat is accepted.
- frame_cnt  output  8  frames completed; wraps 255 -> 0.
- stream  avlst_if.master  -  valid, ready, data[31:0], startofpacket, endofpacket.

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset is asynchronous and active-high. The reset port is named reset.
- Values during and after reset:
  - valid=0, data=0, startofpacket=0, endofpacket=0.
  - frame_done=0, frame_cnt=0.
  - x=0, y=0, state=IDLE.
- Handshake:
  - A beat transfers on a rising edge where valid&&ready.
  - While valid=1 and ready=0, data, startofpacket and endofpacket must hold stable.
  - valid never drops without a transfer, except on reset.
  - The source does not wait for ready before asserting valid.
- State machine:
  - IDLE: valid=0. If enable=1, latch pattern_sel, load beat (0,0) and go to STREAM. valid rises on the next cycle, so latency from enable to first valid is 1 cycle.
  - STREAM, per accepted beat:
    - If not the last beat: x++; on x=H_PIXELS-1 then x=0, y++. The next beat is presented in the following cycle, giving 1 beat/cycle throughput under constant ready.
    - If the last beat (x=H_PIXELS-1 and y=V_PIXELS-1): pulse frame_done and increment frame_cnt.
      - enable=1: relatch pattern_sel and present (0,0) with sop immediately, with no idle cycle between frames.
      - enable=0: go to IDLE and drop valid in the next cycle.
- Sideband flags:
  - startofpacket=1 only for beat (0,0).
  - endofpacket=1 only for beat (H_PIXELS-1, V_PIXELS-1).
  - For V_PIXELS=1 and H_PIXELS=8 the flags still apply to distinct beats.
- enable deasserted mid-frame: the frame completes. Packets are never truncated.
- pattern_sel changed mid-frame: ignored until the next frame start.
- Pixel data: data[31:24]=0, R=data[23:16], G=data[15:8], B=data[7:0]. The pattern uses the latched pattern_sel.
  - 0, colour bars: 8 bars of H_PIXELS/8 pixels, tracked by a bar index b (3 bits) plus a sub-counter. No divider.
    - R = b[2] ? FF : 00.
    - G = b[1] ? FF : 00.
    - B = b[0] ? FF : 00.
  - 1, gradient: R = G = B = x[7:0]; wraps every 256 pixels.
  - 2, checker: (x[4]^y[4]) ? FFFFFF : 000000.
  - 3, frame fill: R = frame_cnt, G = ~frame_cnt, B = y[7:0], using frame_cnt at frame start.
- Counter widths: x and y are $clog2(H_PIXELS) and $clog2(V_PIXELS) bits. frame_cnt wraps modulo 256 with no saturation.
- Reset mid-frame: all outputs go to reset values immediately (asynchronously). After reset is released, the next frame restarts at (0,0) with sop.

Decomposition:
- Package avlst_video_pkg holds:
  - typedef rgb_t (packed struct r, g, b, 8 bits each).
  - typedef pattern_e (PAT_BARS, PAT_GRAD, PAT_CHECK, PAT_FILL).
  - function pack_pixel(rgb_t) returning 32 bits.
- Sub-module avlst_pattern_pixel: purely combinational. Takes x, y, b, pattern and frame_cnt; returns rgb_t.
- The FSM, counters and handshake hold registers stay in the top level.

Test Plan (H_PIXELS=16, V_PIXELS=4 unless noted):
- Reset, then enable=1 with ready always 1 -> valid high from cycle 1, 64 beats in 64 consecutive cycles. sop on beat 0 only, eop on beat 63 only. frame_done pulses with beat 63 and frame_cnt=1. Beat 64 carries sop with no gap.
- Pattern 0 with ready=1 -> data beats 0-1=000000, 2-3=0000FF, ... 14-15=FFFFFF on every line.
- Random ready at 30% duty, pattern 2 -> the sink receives exactly 64 beats per frame. A checker asserts data, sop and eop stable whenever valid && !ready. Pixel (0,0)=000000. With H=64: pixel (16,0)=FFFFFF.
- Drop enable at beat 20 and switch pattern_sel 1->3 at beat 30 -> the frame finishes all 64 beats as gradient (beat 17 data=010101). valid=0 the cycle after eop accept. frame_cnt=1.
- frame_cnt wraps: run 256 frames of pattern 3 with H=8, V=1 -> frame_cnt goes 255 -> 0. Frame 255's first beat has data=00FF0000|{G=00}, i.e. 00FF0000.
- Assert reset at beat 10 while ready=0 -> valid, sop, eop and data go to 0 immediately. After release with enable=1, the first beat is (0,0) with sop=1 and frame_cnt=0.
